spio_chain: RTL and testbench

SPIO_CHAIN -- requirements
Module: spio_chain

---
 rtl/spio_chain_pkg.sv | 22 ++
 rtl/spio_clkgen.sv | 36 +++
 rtl/spio_chain.sv | 131 +++++++++++++
 tb/tb_spio_chain.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spio_chain_pkg.sv
// Shared types and default constants for the serial LED chain driver.
package spio_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    localparam int          DEF_DATA_BITS = 16;
    localparam int          DEF_CLK_DIV   = 2;
    localparam int          DEF_MSB_FIRST = 0;
    localparam int          DEF_INVERT    = 1;
    localparam logic [63:0] DEF_RESET_VAL = 64'h2A;

    // Counter width that stays at least one bit for tiny ranges.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spio_clkgen.sv
// Half-period tick generator: tick every CLK_DIV cycles while run is high, phase toggles on each tick.
module spio_clkgen
    import spio_chain_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick,
    output logic phase
);
    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == LAST_CNT);

    // Held at zero while stopped so every run starts on a fresh low half period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spio_chain.sv
// Parallel LED register with serial shift-out to an external shift/latch chain.
// Optional SPIO_AUTO_REFRESH_EN macro starts a transfer whenever the register content changes.
module spio_chain
    import spio_chain_pkg::*;
#(
    parameter int          DATA_BITS = DEF_DATA_BITS,
    parameter int          CLK_DIV   = DEF_CLK_DIV,
    parameter int          MSB_FIRST = DEF_MSB_FIRST,
    parameter int          INVERT    = DEF_INVERT,
    parameter logic [63:0] RESET_VAL = DEF_RESET_VAL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] p_data,
    output logic [DATA_BITS-1:0] led_out,
    output logic                 led_clk,
    output logic                 led_sout,
    output logic                 led_clrn,
    output logic                 led_pen,
    output logic                 busy,
    output logic                 done
);
    localparam int BW = cnt_width(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   reg_q, reg_now, frame_in, shreg, shifted;
    logic [BW-1:0]          bitcnt;
    logic                   sout_q, done_q, clrn_q;
    logic                   tick, phase, run, refresh;
    logic                   load_go, bit_end, last_bit;

    function automatic logic head_bit(input logic [DATA_BITS-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_BITS-1] : v[0];
    endfunction

    // A write in the launching cycle is folded into the captured frame.
    assign reg_now  = en ? p_data : reg_q;
    assign frame_in = (INVERT != 0) ? ~reg_now : reg_now;
    assign shifted  = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

    assign run      = (state_q == ST_SHIFT) || (state_q == ST_LATCH);
    assign load_go  = (state_q == ST_IDLE) && (state_d == ST_LOAD);
    assign bit_end  = (state_q == ST_SHIFT) && tick && phase;
    assign last_bit = (bitcnt == LAST_BIT);

    spio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .tick  (tick),
        .phase (phase)
    );

`ifdef SPIO_AUTO_REFRESH_EN
    logic dirty_q;

    // A changing write wins over the LOAD clear so a write during LOAD still earns a follow-up frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dirty_q <= 1'b0;
        else if (en && (p_data != reg_q))
            dirty_q <= 1'b1;
        else if (state_q == ST_LOAD)
            dirty_q <= 1'b0;
    end

    assign refresh = dirty_q;
`else
    assign refresh = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        led_pen = (state_q == ST_LATCH);
        led_clk = (state_q == ST_SHIFT) && phase;
        case (state_q)
            ST_IDLE:  if (start || refresh) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (bit_end && last_bit) state_d = ST_LATCH;
            ST_LATCH: if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_q  <= RESET_VAL[DATA_BITS-1:0];
            sout_q <= 1'b0;
            bitcnt <= '0;
            done_q <= 1'b0;
            clrn_q <= 1'b0;
        end else begin
            clrn_q <= 1'b1;
            done_q <= (state_q == ST_LATCH) && tick;
            if (en)
                reg_q <= p_data;
            // Serial data only moves on the high-to-low transition of led_clk.
            if (load_go) begin
                sout_q <= head_bit(frame_in);
                bitcnt <= '0;
            end else if (bit_end && !last_bit) begin
                sout_q <= head_bit(shifted);
                bitcnt <= bitcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_go)
            shreg <= frame_in;
        else if (bit_end)
            shreg <= shifted;
    end

    assign led_out  = reg_q;
    assign led_sout = sout_q;
    assign led_clrn = clrn_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spio_chain.sv
// Bench for spio_chain: two instances (LSB-first inverted, MSB-first plain) share stimulus and are
// checked against a frame-level reference model; refresh scenarios run when SPIO_AUTO_REFRESH_EN is set.
module tb_spio_chain;

    localparam int DB    = 16;
    localparam int CD_A  = 2;
    localparam int MSB_A = 0;
    localparam int INV_A = 1;
    localparam int CD_B  = 3;
    localparam int MSB_B = 1;
    localparam int INV_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic start = 1'b0;
    logic [DB-1:0] p_data = '0;

    logic [DB-1:0] out_a, out_b;
    logic lclk_a, sout_a, clrn_a, pen_a, busy_a, done_a;
    logic lclk_b, sout_b, clrn_b, pen_b, busy_b, done_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spio_chain dut_a (
        .clk(clk), .rst(rst), .en(en), .start(start), .p_data(p_data),
        .led_out(out_a), .led_clk(lclk_a), .led_sout(sout_a), .led_clrn(clrn_a),
        .led_pen(pen_a), .busy(busy_a), .done(done_a)
    );

    spio_chain #(.DATA_BITS(DB), .CLK_DIV(CD_B), .MSB_FIRST(MSB_B), .INVERT(INV_B)) dut_b (
        .clk(clk), .rst(rst), .en(en), .start(start), .p_data(p_data),
        .led_out(out_b), .led_clk(lclk_b), .led_sout(sout_b), .led_clrn(clrn_b),
        .led_pen(pen_b), .busy(busy_b), .done(done_b)
    );

    // Frame model: k-th transmitted bit from the register word, order and polarity only.
    function automatic logic [DB-1:0] exp_word(input logic [DB-1:0] v, input int msb, input int inv);
        logic [DB-1:0] w;
        for (int k = 0; k < DB; k++) begin
            w[k] = (msb != 0) ? v[DB-1-k] : v[k];
            if (inv != 0) w[k] = ~w[k];
        end
        return w;
    endfunction

    // Serial-side observers, sampled on the falling edge.
    bit q_a[$];
    bit q_b[$];
    int pen_na, busy_na, done_na, done_cyc_a, glitch_a;
    int pen_nb, busy_nb, done_nb, done_cyc_b, glitch_b;
    logic pclk_a = 1'b0, psout_a = 1'b0, pclk_b = 1'b0, psout_b = 1'b0;

    always @(negedge clk) begin
        if (lclk_a && !pclk_a) q_a.push_back(sout_a);
        if (lclk_a && (sout_a !== psout_a)) glitch_a = glitch_a + 1;
        if (pen_a) pen_na = pen_na + 1;
        if (busy_a) busy_na = busy_na + 1;
        if (done_a) begin done_na = done_na + 1; done_cyc_a = cyc; end
        pclk_a = lclk_a;
        psout_a = sout_a;
    end

    always @(negedge clk) begin
        if (lclk_b && !pclk_b) q_b.push_back(sout_b);
        if (lclk_b && (sout_b !== psout_b)) glitch_b = glitch_b + 1;
        if (pen_b) pen_nb = pen_nb + 1;
        if (busy_b) busy_nb = busy_nb + 1;
        if (done_b) begin done_nb = done_nb + 1; done_cyc_b = cyc; end
        pclk_b = lclk_b;
        psout_b = sout_b;
    end

    task automatic clear_mon();
        q_a.delete(); q_b.delete();
        pen_na = 0; busy_na = 0; done_na = 0; done_cyc_a = 0; glitch_a = 0;
        pen_nb = 0; busy_nb = 0; done_nb = 0; done_cyc_b = 0; glitch_b = 0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_na >= n && done_nb >= n) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s timeout: done_a=%0d done_b=%0d want %0d", name, done_na, done_nb, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_a !== 16'h002A) begin n_err++; $display("FAIL rst_led_out_a got %h want 002a", out_a); end
        n_cmp++; if (out_b !== 16'h002A) begin n_err++; $display("FAIL rst_led_out_b got %h want 002a", out_b); end
        n_cmp++; if ({lclk_a, sout_a, pen_a, busy_a, done_a, clrn_a} !== 6'b0) begin
            n_err++; $display("FAIL rst_outs_a got %b want 000000", {lclk_a, sout_a, pen_a, busy_a, done_a, clrn_a});
        end
        n_cmp++; if ({lclk_b, sout_b, pen_b, busy_b, done_b, clrn_b} !== 6'b0) begin
            n_err++; $display("FAIL rst_outs_b got %b want 000000", {lclk_b, sout_b, pen_b, busy_b, done_b, clrn_b});
        end
        @(negedge clk); #1 rst = 1'b1;
        #1;
        n_cmp++; if (clrn_a !== 1'b0) begin n_err++; $display("FAIL clrn_before_edge got %b want 0", clrn_a); end
        @(posedge clk); #1;
        n_cmp++; if ({clrn_a, clrn_b} !== 2'b11) begin n_err++; $display("FAIL clrn_after_edge got %b want 11", {clrn_a, clrn_b}); end
        n_cmp++; if ({lclk_a, sout_a, pen_a, busy_a, done_a} !== 5'b0) begin
            n_err++; $display("FAIL idle_after_rst got %b want 00000", {lclk_a, sout_a, pen_a, busy_a, done_a});
        end
    endtask

    task automatic run_transfer(input logic [DB-1:0] v, input bit same, input string name);
        int t;
        logic [DB-1:0] wa, wb, ea, eb;
        if (!same) begin
            @(posedge clk); #1; en = 1'b1; p_data = v;
        end
        @(posedge clk); #1;
        clear_mon();
        en = same; p_data = v; start = 1'b1; t = cyc;
        @(posedge clk); #1;
        en = 1'b0; start = 1'b0; p_data = 16'($urandom);
        wait_done(1, 400, name);
        repeat (10) @(negedge clk);
        ea = exp_word(v, MSB_A, INV_A);
        eb = exp_word(v, MSB_B, INV_B);
        wa = '0; wb = '0;
        for (int k = 0; k < DB; k++) begin
            if (k < q_a.size()) wa[k] = q_a[k];
            if (k < q_b.size()) wb[k] = q_b[k];
        end
        n_cmp++; if (out_a !== v) begin n_err++; $display("FAIL %s led_out got %h want %h", name, out_a, v); end
        n_cmp++; if (q_a.size() != DB) begin n_err++; $display("FAIL %s clk_pulses_a got %0d want %0d", name, q_a.size(), DB); end
        n_cmp++; if (q_b.size() != DB) begin n_err++; $display("FAIL %s clk_pulses_b got %0d want %0d", name, q_b.size(), DB); end
        n_cmp++; if (wa !== ea) begin n_err++; $display("FAIL %s bits_a got %h want %h", name, wa, ea); end
        n_cmp++; if (wb !== eb) begin n_err++; $display("FAIL %s bits_b got %h want %h", name, wb, eb); end
        n_cmp++; if (pen_na != CD_A || pen_nb != CD_B) begin
            n_err++; $display("FAIL %s pen_cycles got %0d/%0d want %0d/%0d", name, pen_na, pen_nb, CD_A, CD_B);
        end
        n_cmp++; if (busy_na != 2*CD_A*DB + CD_A + 1 || busy_nb != 2*CD_B*DB + CD_B + 1) begin
            n_err++; $display("FAIL %s busy_cycles got %0d/%0d want %0d/%0d", name, busy_na, busy_nb,
                              2*CD_A*DB + CD_A + 1, 2*CD_B*DB + CD_B + 1);
        end
        n_cmp++; if (done_cyc_a - t != 2*CD_A*DB + CD_A + 2 || done_cyc_b - t != 2*CD_B*DB + CD_B + 2) begin
            n_err++; $display("FAIL %s done_latency got %0d/%0d want %0d/%0d", name, done_cyc_a - t, done_cyc_b - t,
                              2*CD_A*DB + CD_A + 2, 2*CD_B*DB + CD_B + 2);
        end
        n_cmp++; if (done_na != 1 || done_nb != 1) begin
            n_err++; $display("FAIL %s done_pulses got %0d/%0d want 1/1", name, done_na, done_nb);
        end
        n_cmp++; if (glitch_a != 0 || glitch_b != 0) begin
            n_err++; $display("FAIL %s sout_moved_while_clk_high got %0d/%0d want 0/0", name, glitch_a, glitch_b);
        end
        n_cmp++; if (sout_a !== ea[DB-1] || sout_b !== eb[DB-1]) begin
            n_err++; $display("FAIL %s idle_sout got %b%b want %b%b", name, sout_a, sout_b, ea[DB-1], eb[DB-1]);
        end
        n_cmp++; if ({lclk_a, pen_a, busy_a, lclk_b, pen_b, busy_b} !== 6'b0) begin
            n_err++; $display("FAIL %s idle_outs got %b want 000000", name, {lclk_a, pen_a, busy_a, lclk_b, pen_b, busy_b});
        end
    endtask

    task automatic test_basic();
        run_transfer(16'h8001, 1'b0, "frame_8001");
        run_transfer(16'h00F0, 1'b0, "frame_00f0");
    endtask

    task automatic test_same_cycle();
        run_transfer(16'h1234, 1'b1, "same_cycle_1234");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_transfer(16'($urandom), 1'($urandom_range(0, 1)), "random_frame");
        end
    endtask

    task automatic test_start_during_busy();
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (350) @(negedge clk);
        n_cmp++; if (done_na != 1 || done_nb != 1) begin
            n_err++; $display("FAIL start_during_busy done_pulses got %0d/%0d want 1/1", done_na, done_nb);
        end
        n_cmp++; if (q_a.size() != DB || q_b.size() != DB) begin
            n_err++; $display("FAIL start_during_busy clk_pulses got %0d/%0d want %0d", q_a.size(), q_b.size(), DB);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok = 1'b0;
        @(posedge clk); #1;
        clear_mon();
        en = 1'b1; p_data = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1 en = 1'b0; start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q_a.size() == 7) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL reset_mid reach_bit7 timeout got %0d bits want 7", q_a.size()); end
        @(posedge clk); #2 rst = 1'b0;
        #1;
        n_cmp++; if (out_a !== 16'h002A) begin n_err++; $display("FAIL reset_mid led_out got %h want 002a", out_a); end
        n_cmp++; if ({lclk_a, sout_a, pen_a, busy_a, done_a, clrn_a} !== 6'b0) begin
            n_err++; $display("FAIL reset_mid outs_a got %b want 000000", {lclk_a, sout_a, pen_a, busy_a, done_a, clrn_a});
        end
        n_cmp++; if ({busy_b, pen_b, done_b, clrn_b} !== 4'b0) begin
            n_err++; $display("FAIL reset_mid outs_b got %b want 0000", {busy_b, pen_b, done_b, clrn_b});
        end
        clear_mon();
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (clrn_a !== 1'b1) begin n_err++; $display("FAIL reset_mid clrn got %b want 1", clrn_a); end
        repeat (200) @(negedge clk);
        n_cmp++; if (pen_na != 0 || done_na != 0 || pen_nb != 0 || done_nb != 0 || busy_na != 0) begin
            n_err++; $display("FAIL reset_mid aborted pen=%0d/%0d done=%0d/%0d busy=%0d want all 0",
                              pen_na, pen_nb, done_na, done_nb, busy_na);
        end
    endtask

`ifdef SPIO_AUTO_REFRESH_EN
    task automatic test_refresh();
        logic [DB-1:0] v1, v2, wa, ea;
        int t;
        @(posedge clk); #1;
        clear_mon();
        en = 1'b1; p_data = out_a;
        @(posedge clk); #1 en = 1'b0;
        repeat (150) @(negedge clk);
        n_cmp++; if (done_na != 0 || done_nb != 0) begin
            n_err++; $display("FAIL refresh_same_value done got %0d/%0d want 0/0", done_na, done_nb);
        end
        v1 = out_a ^ 16'h5A5A;
        @(posedge clk); #1;
        clear_mon();
        en = 1'b1; p_data = v1; t = cyc;
        @(posedge clk); #1 en = 1'b0;
        wait_done(1, 400, "refresh_new_value");
        repeat (150) @(negedge clk);
        ea = exp_word(v1, MSB_A, INV_A);
        wa = '0;
        for (int k = 0; k < DB; k++) if (k < q_a.size()) wa[k] = q_a[k];
        n_cmp++; if (wa !== ea || done_na != 1) begin
            n_err++; $display("FAIL refresh_new_value bits got %h x%0d want %h x1", wa, done_na, ea);
        end
        n_cmp++; if (done_cyc_a - t != 2*CD_A*DB + CD_A + 3) begin
            n_err++; $display("FAIL refresh_new_value latency got %0d want %0d", done_cyc_a - t, 2*CD_A*DB + CD_A + 3);
        end
        v2 = v1 ^ 16'h0FF0;
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 en = 1'b1; p_data = v2;
        @(posedge clk); #1 en = 1'b0;
        wait_done(2, 600, "refresh_during_busy");
        repeat (300) @(negedge clk);
        ea = exp_word(v2, MSB_A, INV_A);
        wa = '0;
        for (int k = 0; k < DB; k++) if (DB + k < q_a.size()) wa[k] = q_a[DB + k];
        n_cmp++; if (done_na != 2 || done_nb != 2) begin
            n_err++; $display("FAIL refresh_during_busy frames got %0d/%0d want 2/2", done_na, done_nb);
        end
        n_cmp++; if (wa !== ea) begin
            n_err++; $display("FAIL refresh_during_busy second_frame got %h want %h", wa, ea);
        end
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_same_cycle();
        test_random();
        test_start_during_busy();
        test_reset_mid_frame();
`ifdef SPIO_AUTO_REFRESH_EN
        test_refresh();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
